// File: rtl/instruction_decode_pkg.sv
// Shared widths, ALU one-hot bit positions and the decoded-op layout for the ID stage.
package instruction_decode_pkg;

  localparam int unsigned FETCH_TO_DEC_BUS_WD = 64;
  localparam int unsigned BR_BUS_WD           = 33;
  localparam int unsigned DEC_TO_EXE_BUS_WD   = 150;
  localparam int unsigned WB_TO_RF_BUS_WD     = 38;

  localparam int unsigned AluOpWd = 12;
  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSlt  = 2;
  localparam int unsigned AluSltu = 3;
  localparam int unsigned AluAnd  = 4;
  localparam int unsigned AluNor  = 5;
  localparam int unsigned AluOr   = 6;
  localparam int unsigned AluXor  = 7;
  localparam int unsigned AluSll  = 8;
  localparam int unsigned AluSrl  = 9;
  localparam int unsigned AluSra  = 10;
  localparam int unsigned AluLui  = 11;

  typedef struct packed {
    logic [AluOpWd-1:0] alu_op;
    logic               src1_is_pc;
    logic               src2_is_imm;
    logic               res_from_mem;
    logic               mem_we;
    logic               gr_we;
    logic [4:0]         dest;
    logic [31:0]        imm;
    logic [31:0]        rj_value;
    logic [31:0]        rkd_value;
    logic [31:0]        pc;
  } dec_to_exe_t;

  // r0 never conflicts; a nonzero source matching any in-flight dest must wait.
  function automatic logic reg_conflict(input logic [4:0] src, input logic [4:0] exe_d,
                                        input logic [4:0] mem_d, input logic [4:0] wb_d);
    return (src != 5'd0) && ((src == exe_d) || (src == mem_d) || (src == wb_d));
  endfunction

endpackage

// File: rtl/instruction_decode_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, r0 hardwired to 0.
module instruction_decode_regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Same-cycle write is not bypassed; the wb_dest interlock covers that case.
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];

endmodule

// File: rtl/instruction_decode.sv
// LA32R ID stage: latches {inst,pc} from IF, decodes, reads the regfile, resolves branches, interlocks.
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetch_to_dec_valid,
  input  logic [FETCH_TO_DEC_BUS_WD-1:0] fetch_to_decode_bus,
  output logic                           dec_allowin,
  output logic [BR_BUS_WD-1:0]           branch_bus,
  input  logic                           exe_allowin,
  output logic                           dec_to_exe_valid,
  output logic [DEC_TO_EXE_BUS_WD-1:0]   dec_to_exe_bus,
  input  logic [4:0]                     exe_dest,
  input  logic [4:0]                     mem_dest,
  input  logic [4:0]                     wb_dest,
  input  logic [WB_TO_RF_BUS_WD-1:0]     wb_to_rf_bus
);

  logic                           dec_valid_q;
  logic [FETCH_TO_DEC_BUS_WD-1:0] fd_bus_q;
  logic                           dec_ready_go;
  logic                           br_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid_q <= 1'b0;
      fd_bus_q    <= '0;
    end else if (dec_allowin) begin
      // The sequential pc+4 fetched behind a taken branch is dropped here.
      dec_valid_q <= fetch_to_dec_valid & ~br_taken;
      if (fetch_to_dec_valid) begin
        fd_bus_q <= fetch_to_decode_bus;
      end
    end
  end

  logic [31:0] inst, pc;
  logic [4:0]  rd, rj, rk;
  assign {inst, pc} = fd_bus_q;
  assign rd = inst[4:0];
  assign rj = inst[9:5];
  assign rk = inst[14:10];

  logic op_add, op_sub, op_slt, op_sltu, op_nor, op_and, op_or, op_xor;
  logic op_slli, op_srli, op_srai, op_addi, op_ld, op_st, op_lu12i;
  logic op_jirl, op_b, op_bl, op_beq, op_bne;
  logic op_3r, op_sft, op_mem;

  assign op_add   = inst[31:15] == 17'h00020;
  assign op_sub   = inst[31:15] == 17'h00022;
  assign op_slt   = inst[31:15] == 17'h00024;
  assign op_sltu  = inst[31:15] == 17'h00025;
  assign op_nor   = inst[31:15] == 17'h00028;
  assign op_and   = inst[31:15] == 17'h00029;
  assign op_or    = inst[31:15] == 17'h0002a;
  assign op_xor   = inst[31:15] == 17'h0002b;
  assign op_slli  = inst[31:15] == 17'h00081;
  assign op_srli  = inst[31:15] == 17'h00089;
  assign op_srai  = inst[31:15] == 17'h00091;
  assign op_addi  = inst[31:22] == 10'h00a;
  assign op_ld    = inst[31:22] == 10'h0a2;
  assign op_st    = inst[31:22] == 10'h0a6;
  assign op_lu12i = inst[31:25] == 7'h0a;
  assign op_jirl  = inst[31:26] == 6'h13;
  assign op_b     = inst[31:26] == 6'h14;
  assign op_bl    = inst[31:26] == 6'h15;
  assign op_beq   = inst[31:26] == 6'h16;
  assign op_bne   = inst[31:26] == 6'h17;

  assign op_3r  = op_add | op_sub | op_slt | op_sltu | op_nor | op_and | op_or | op_xor;
  assign op_sft = op_slli | op_srli | op_srai;
  assign op_mem = op_ld | op_st;

  logic [4:0]  raddr2;
  logic [31:0] rj_value, rkd_value;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign {rf_we, rf_waddr, rf_wdata} = wb_to_rf_bus;
  assign raddr2 = (op_beq | op_bne | op_st) ? rd : rk;

  instruction_decode_regfile u_regfile (
    .clk    (clk),
    .raddr1 (rj),
    .rdata1 (rj_value),
    .raddr2 (raddr2),
    .rdata2 (rkd_value),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  logic use_rj, use_rkd, hazard;
  assign use_rj  = op_3r | op_sft | op_addi | op_mem | op_jirl | op_beq | op_bne;
  assign use_rkd = op_3r | op_beq | op_bne | op_st;
  assign hazard  = dec_valid_q &
                   ((use_rj  & reg_conflict(rj, exe_dest, mem_dest, wb_dest)) |
                    (use_rkd & reg_conflict(raddr2, exe_dest, mem_dest, wb_dest)));

  logic [31:0] offs16, offs26, br_target;
  logic        br_cond;
  assign offs16  = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26  = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign br_cond = op_b | op_bl | op_jirl | (op_beq & (rj_value == rkd_value)) |
                   (op_bne & (rj_value != rkd_value));

  always_comb begin
    br_target    = op_jirl ? (rj_value + offs16) : (pc + ((op_b | op_bl) ? offs26 : offs16));
    dec_ready_go = ~hazard;
    br_taken     = dec_valid_q & dec_ready_go & br_cond;
    branch_bus   = {br_taken, br_target};
    dec_allowin      = ~dec_valid_q | (dec_ready_go & exe_allowin);
    dec_to_exe_valid = dec_valid_q & dec_ready_go;
  end

  dec_to_exe_t ex;

  always_comb begin
    ex = '0;
    ex.alu_op[AluAdd]  = op_add | op_addi | op_mem | op_jirl | op_bl;
    ex.alu_op[AluSub]  = op_sub;
    ex.alu_op[AluSlt]  = op_slt;
    ex.alu_op[AluSltu] = op_sltu;
    ex.alu_op[AluAnd]  = op_and;
    ex.alu_op[AluNor]  = op_nor;
    ex.alu_op[AluOr]   = op_or;
    ex.alu_op[AluXor]  = op_xor;
    ex.alu_op[AluSll]  = op_slli;
    ex.alu_op[AluSrl]  = op_srli;
    ex.alu_op[AluSra]  = op_srai;
    ex.alu_op[AluLui]  = op_lu12i;
    // Link ops compute pc+4 through the adder.
    ex.src1_is_pc   = op_jirl | op_bl;
    ex.src2_is_imm  = op_sft | op_addi | op_mem | op_lu12i | op_jirl | op_bl;
    ex.res_from_mem = op_ld;
    ex.mem_we       = op_st;
    ex.gr_we        = op_3r | op_sft | op_addi | op_ld | op_lu12i | op_jirl | op_bl;
    ex.dest         = !ex.gr_we ? 5'd0 : (op_bl ? 5'd1 : rd);
    if (op_addi | op_mem) begin
      ex.imm = {{20{inst[21]}}, inst[21:10]};
    end else if (op_sft) begin
      ex.imm = {27'd0, rk};
    end else if (op_lu12i) begin
      ex.imm = {inst[24:5], 12'd0};
    end else if (op_jirl | op_bl) begin
      ex.imm = 32'd4;
    end
    ex.rj_value  = rj_value;
    ex.rkd_value = rkd_value;
    ex.pc        = pc;
  end

  assign dec_to_exe_bus = ex;

endmodule

// File: tb/tb_instruction_decode.sv
// Randomized bench for instruction_decode against a table-driven reference model of the ID stage.
module tb_instruction_decode;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_to_dec_valid;
  logic [63:0]  fetch_to_decode_bus;
  logic         dec_allowin;
  logic [32:0]  branch_bus;
  logic         exe_allowin;
  logic         dec_to_exe_valid;
  logic [149:0] dec_to_exe_bus;
  logic [4:0]   exe_dest, mem_dest, wb_dest;
  logic [37:0]  wb_to_rf_bus;

  instruction_decode dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch_to_dec_valid  (fetch_to_dec_valid),
    .fetch_to_decode_bus (fetch_to_decode_bus),
    .dec_allowin         (dec_allowin),
    .branch_bus          (branch_bus),
    .exe_allowin         (exe_allowin),
    .dec_to_exe_valid    (dec_to_exe_valid),
    .dec_to_exe_bus      (dec_to_exe_bus),
    .exe_dest            (exe_dest),
    .mem_dest            (mem_dest),
    .wb_dest             (wb_dest),
    .wb_to_rf_bus        (wb_to_rf_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [149:0] got, input logic [149:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef enum int {
    MnAdd, MnSub, MnSlt, MnSltu, MnNor, MnAnd, MnOr, MnXor, MnSlli, MnSrli, MnSrai,
    MnAddi, MnLd, MnSt, MnLu12i, MnJirl, MnB, MnBl, MnBeq, MnBne, MnNop
  } mn_e;

  localparam int OpSh [20] = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15,
                               22, 22, 22, 25, 26, 26, 26, 26, 26};
  localparam int OpKey [20] = '{'h20, 'h22, 'h24, 'h25, 'h28, 'h29, 'h2a, 'h2b, 'h81, 'h89,
                                'h91, 'h0a, 'ha2, 'ha6, 'h0a, 'h13, 'h14, 'h15, 'h16, 'h17};
  // ALU one-hot position per mnemonic; -1 = no ALU op.
  localparam int AluBit [20] = '{0, 1, 2, 3, 5, 4, 6, 7, 8, 9, 10, 0, 0, 0, 11, 0, -1, 0, -1, -1};

  logic [31:0] m_regs [32];
  bit          m_valid;
  logic [31:0] m_inst, m_pc;

  function automatic mn_e mnemonic(input logic [31:0] i);
    for (int k = 0; k < 20; k++) begin
      if ((i >> OpSh[k]) == 32'(OpKey[k])) return mn_e'(k);
    end
    return MnNop;
  endfunction

  function automatic void predict(input logic [31:0] i, input logic [31:0] pc,
                                  output logic [149:0] bus, output bit br,
                                  output logic [31:0] tgt, output logic [4:0] sa,
                                  output logic [4:0] sb);
    mn_e         mn;
    logic [4:0]  rd, rj, rk, r2, dest;
    logic [11:0] alu;
    logic [31:0] imm, vj, vk;
    bit          three, sft, we, s1pc, s2imm, ld, st;
    int          s12, o16, o26;
    mn    = mnemonic(i);
    rd    = i[4:0];
    rj    = i[9:5];
    rk    = i[14:10];
    three = mn inside {MnAdd, MnSub, MnSlt, MnSltu, MnNor, MnAnd, MnOr, MnXor};
    sft   = mn inside {MnSlli, MnSrli, MnSrai};
    r2    = (mn inside {MnBeq, MnBne, MnSt}) ? rd : rk;
    vj    = m_regs[rj];
    vk    = m_regs[r2];
    alu   = '0;
    if (mn != MnNop && AluBit[mn] >= 0) alu[AluBit[mn]] = 1'b1;
    s12 = int'(i[21:10]);
    if (s12 >= 2048) s12 -= 4096;
    o16 = int'(i[25:10]);
    if (o16 >= 32768) o16 -= 65536;
    o16 *= 4;
    o26 = int'({i[9:0], i[25:10]});
    if (o26 >= (1 << 25)) o26 -= (1 << 26);
    o26 *= 4;
    imm = '0;
    if (mn inside {MnAddi, MnLd, MnSt}) imm = 32'(s12);
    else if (sft) imm = 32'(rk);
    else if (mn == MnLu12i) imm = 32'(i[24:5]) * 32'd4096;
    else if (mn inside {MnJirl, MnBl}) imm = 32'd4;
    we    = !(mn inside {MnSt, MnB, MnBeq, MnBne, MnNop});
    dest  = !we ? 5'd0 : ((mn == MnBl) ? 5'd1 : rd);
    s1pc  = mn inside {MnJirl, MnBl};
    s2imm = sft || (mn inside {MnAddi, MnLd, MnSt, MnLu12i, MnJirl, MnBl});
    ld    = (mn == MnLd);
    st    = (mn == MnSt);
    bus   = {alu, s1pc, s2imm, ld, st, we, dest, imm, vj, vk, pc};
    sa    = (three || sft || (mn inside {MnAddi, MnLd, MnSt, MnJirl, MnBeq, MnBne})) ? rj : 5'd0;
    sb    = (three || (mn inside {MnBeq, MnBne, MnSt})) ? r2 : 5'd0;
    br    = (mn inside {MnB, MnBl, MnJirl}) || (mn == MnBeq && vj == vk) ||
            (mn == MnBne && vj != vk);
    if (mn == MnJirl) tgt = vj + 32'(o16);
    else tgt = pc + 32'((mn inside {MnB, MnBl}) ? o26 : o16);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    int          k;
    if ($urandom_range(0, 7) == 0) return $urandom;
    k = $urandom_range(0, 19);
    i = $urandom;
    i = (i & ((32'd1 << OpSh[k]) - 32'd1)) | (32'(OpKey[k]) << OpSh[k]);
    if ($urandom_range(0, 3) != 0) begin
      i[4:0]   = 5'($urandom_range(0, 3));
      i[9:5]   = 5'($urandom_range(0, 3));
      i[14:10] = 5'($urandom_range(0, 3));
    end
    return i;
  endfunction

  // One cycle: drive, compare against the model, clock, advance the model.
  task automatic step(input bit fv, input logic [31:0] inst, input logic [31:0] pc,
                      input bit ea, input logic [4:0] ed, input logic [4:0] md,
                      input logic [4:0] wd, input bit we, input logic [4:0] wa,
                      input logic [31:0] wdat);
    logic [149:0] ebus;
    logic [31:0]  etgt;
    logic [4:0]   sa, sb;
    bit           ebr, haz, go, taken, allow;
    fetch_to_dec_valid  = fv;
    fetch_to_decode_bus = {inst, pc};
    exe_allowin         = ea;
    exe_dest            = ed;
    mem_dest            = md;
    wb_dest             = wd;
    wb_to_rf_bus        = {we, wa, wdat};
    #1;
    predict(m_inst, m_pc, ebus, ebr, etgt, sa, sb);
    haz   = m_valid && ((sa != 0 && (sa == ed || sa == md || sa == wd)) ||
                        (sb != 0 && (sb == ed || sb == md || sb == wd)));
    go    = !haz;
    taken = m_valid && go && ebr;
    allow = !m_valid || (go && ea);
    check("dec_allowin", dec_allowin, allow);
    check("dec_to_exe_valid", dec_to_exe_valid, m_valid && go);
    check("br_taken", branch_bus[32], taken);
    if (taken) check("br_target", branch_bus[31:0], etgt);
    if (m_valid && go) check("dec_to_exe_bus", dec_to_exe_bus, ebus);
    @(posedge clk);
    if (allow) begin
      m_valid = fv && !taken;
      if (fv) begin
        m_inst = inst;
        m_pc   = pc;
      end
    end
    if (we && wa != 0) m_regs[wa] = wdat;
    #1;
  endtask

  initial begin
    reset               = 1'b1;
    fetch_to_dec_valid  = 1'b0;
    fetch_to_decode_bus = '0;
    exe_allowin         = 1'b0;
    exe_dest            = '0;
    mem_dest            = '0;
    wb_dest             = '0;
    wb_to_rf_bus        = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset_allowin", dec_allowin, 1'b1);
    check("reset_valid", dec_to_exe_valid, 1'b0);
    check("reset_branch_bus", branch_bus, 33'd0);
    m_valid = 0;
    m_inst  = '0;
    m_pc    = '0;
    for (int r = 0; r < 32; r++) m_regs[r] = '0;

    for (int r = 1; r < 32; r++) step(0, 0, 0, 1, 0, 0, 0, 1, 5'(r), $urandom);
    step(0, 0, 0, 1, 0, 0, 0, 1, 5'd1, 32'h1c001000);
    step(0, 0, 0, 1, 0, 0, 0, 1, 5'd2, 32'h1c001000);

    // addi.w r4,r0,5
    step(1, 32'h02801404, 32'h1c000000, 1, 0, 0, 0, 0, 0, 0);
    check("addi_valid", dec_to_exe_valid, 1'b1);
    check("addi_dest", dec_to_exe_bus[132:128], 5'd4);
    check("addi_imm", dec_to_exe_bus[127:96], 32'd5);
    check("addi_gr_we", dec_to_exe_bus[133], 1'b1);

    // add.w r5,r4,r4 stalls while r4 is in flight
    step(1, 32'h00101085, 32'h1c000004, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5'd4, 0, 0, 0, 0, 0);
    check("raw_allowin", dec_allowin, 1'b0);
    check("raw_valid", dec_to_exe_valid, 1'b0);
    step(0, 0, 0, 1, 0, 5'd4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 5'd4, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // beq r0,r0,+8 then the wrong-path pc+4
    step(1, 32'h58000800, 32'h1c000010, 1, 0, 0, 0, 0, 0, 0);
    check("beq_branch_bus", branch_bus, {1'b1, 32'h1c000018});
    step(1, 32'h02801404, 32'h1c000014, 1, 0, 0, 0, 0, 0, 0);
    check("beq_kill", dec_to_exe_valid, 1'b0);

    // bne r1,r2 with r1==r2
    step(1, 32'h5c000022, 32'h1c000020, 1, 0, 0, 0, 0, 0, 0);
    check("bne_not_taken", branch_bus[32], 1'b0);
    check("bne_valid", dec_to_exe_valid, 1'b1);
    check("bne_gr_we", dec_to_exe_bus[133], 1'b0);

    // jirl r1,r2,0, then held by exe_allowin=0
    step(1, 32'h4c000041, 32'h1c000024, 1, 0, 0, 0, 0, 0, 0);
    check("jirl_branch_bus", branch_bus, {1'b1, 32'h1c001000});
    step(1, 32'h02801404, 32'h1c000028, 0, 0, 0, 0, 0, 0, 0);
    check("jirl_hold_taken", branch_bus, {1'b1, 32'h1c001000});
    check("jirl_hold_allowin", dec_allowin, 1'b0);
    check("jirl_dest", dec_to_exe_bus[132:128], 5'd1);
    check("jirl_src1_is_pc", dec_to_exe_bus[137], 1'b1);
    check("jirl_imm", dec_to_exe_bus[127:96], 32'd4);

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] d [3];
      for (int k = 0; k < 3; k++) begin
        d[k] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
      end
      step($urandom_range(0, 3) != 0, rand_inst(), {$urandom_range(0, 32'h3fffffff), 2'b00},
           $urandom_range(0, 3) != 0, d[0], d[1], d[2], $urandom_range(0, 1) == 1,
           ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom),
           ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
